// File: rtl/algo_1r6w_wr_feeder_pkg.sv
// Shared types and constants for the 1r6w write-side feeder.
package algo_1r6w_wr_feeder_pkg;

  localparam int unsigned NUMWRPT = 6;
  localparam logic [8:0] BP_THR_DEFAULT = 9'd64;

  typedef enum logic [1:0] {
    StWaitRdy,
    StRun,
    StDrain,
    StDone
  } state_e;

  function automatic logic [31:0] popcount(input logic [NUMWRPT-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < NUMWRPT; i++) begin
      c = c + {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/algo_1r6w_wr_feeder_if.sv
// Ingress streams, memory write bus and quiesce handshake of the write feeder.
interface algo_1r6w_wr_feeder_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned BITADDR = 13,
  parameter int unsigned NUMWRPT = 6
);
  logic [NUMWRPT-1:0]         in_vld;
  logic [NUMWRPT-1:0]         in_rdy;
  logic [NUMWRPT*BITADDR-1:0] in_adr;
  logic [NUMWRPT*WIDTH-1:0]   in_din;
  logic                       mem_ready;
  logic                       wr_bp;
  logic [NUMWRPT-1:0]         write;
  logic [NUMWRPT*BITADDR-1:0] wr_adr;
  logic [NUMWRPT*WIDTH-1:0]   din;
  logic [8:0]                 bp_thr;
  logic                       flush;
  logic                       flush_done;
  logic [31:0]                wr_cnt;

  // Feeder side.
  modport master (
    input  in_vld, in_adr, in_din, mem_ready, wr_bp, flush,
    output in_rdy, write, wr_adr, din, bp_thr, flush_done, wr_cnt
  );

  // Producer / memory / software side.
  modport slave (
    output in_vld, in_adr, in_din, mem_ready, wr_bp, flush,
    input  in_rdy, write, wr_adr, din, bp_thr, flush_done, wr_cnt
  );
endinterface

// File: rtl/algo_wr_fifo.sv
// Single-port synchronous FIFO; storage is not reset, only the pointers are.
module algo_wr_fifo #(
  parameter int unsigned DW      = 45,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned BITFIFO = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [DW-1:0]      mem_q [DEPTH];
  logic [BITFIFO-1:0] wr_ptr_q, rd_ptr_q;
  logic [BITFIFO:0]   occ_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + BITFIFO'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + BITFIFO'(1);
      unique case ({push_i, pop_i})
        2'b10:   occ_q <= occ_q + (BITFIFO+1)'(1);
        2'b01:   occ_q <= occ_q - (BITFIFO+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (occ_q == (BITFIFO+1)'(DEPTH));
  assign empty_o = (occ_q == '0);
endmodule

// File: rtl/algo_1r6w_wr_feeder.sv
// Write-side initiator: per-port ingress FIFOs feeding the 1r6w memory write bus.
module algo_1r6w_wr_feeder
  import algo_1r6w_wr_feeder_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned BITADDR = 13,
  parameter int unsigned NUMWRPT = algo_1r6w_wr_feeder_pkg::NUMWRPT,
  parameter int unsigned FIFODEP = 4,
  parameter int unsigned BITFIFO = 2,
  parameter logic [8:0]  BP_THR  = BP_THR_DEFAULT
) (
  input logic                    clk,
  input logic                    rst,
  algo_1r6w_wr_feeder_if.master  bus
);
  localparam int unsigned EntW = BITADDR + WIDTH;

  state_e                     state_q, state_d;
  logic [NUMWRPT-1:0]         push, pop, full, empty, rdy;
  logic [EntW-1:0]            head [NUMWRPT];
  logic [NUMWRPT-1:0]         write_q, write_d;
  logic [NUMWRPT*BITADDR-1:0] wr_adr_q, wr_adr_d;
  logic [NUMWRPT*WIDTH-1:0]   din_q, din_d;
  logic [31:0]                wr_cnt_q, wr_cnt_d;
  logic                       flush_done;

  assign push = bus.in_vld & rdy;

  for (genvar p = 0; p < NUMWRPT; p++) begin : g_fifo
    algo_wr_fifo #(
      .DW      (EntW),
      .DEPTH   (FIFODEP),
      .BITFIFO (BITFIFO)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[p]),
      .pop_i   (pop[p]),
      .wdata_i ({bus.in_adr[p*BITADDR +: BITADDR], bus.in_din[p*WIDTH +: WIDTH]}),
      .rdata_o (head[p]),
      .full_o  (full[p]),
      .empty_o (empty[p])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StWaitRdy;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitRdy: if (bus.mem_ready) state_d = StRun;
      StRun: begin
        if (!bus.mem_ready)  state_d = StWaitRdy;
        else if (bus.flush)  state_d = StDrain;
      end
      StDrain: begin
        // Done only once the last popped word has also left the output register.
        if (!bus.mem_ready)                   state_d = StWaitRdy;
        else if (&empty && (write_q == '0))   state_d = StDone;
      end
      StDone:  state_d = StRun;
      default: state_d = StWaitRdy;
    endcase
  end

  always_comb begin
    rdy        = '0;
    pop        = '0;
    flush_done = (state_q == StDone);
    if ((state_q == StRun) || (state_q == StDone)) rdy = ~full;
    if (((state_q == StRun) || (state_q == StDrain)) && !bus.wr_bp) pop = ~empty;
  end

  always_comb begin
    write_d  = pop;
    wr_adr_d = wr_adr_q;
    din_d    = din_q;
    for (int p = 0; p < NUMWRPT; p++) begin
      if (pop[p]) begin
        wr_adr_d[p*BITADDR +: BITADDR] = head[p][WIDTH +: BITADDR];
        din_d[p*WIDTH +: WIDTH]        = head[p][0 +: WIDTH];
      end
    end
    wr_cnt_d = wr_cnt_q + popcount(write_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q  <= '0;
      wr_adr_q <= '0;
      din_q    <= '0;
      wr_cnt_q <= '0;
    end else begin
      write_q  <= write_d;
      wr_adr_q <= wr_adr_d;
      din_q    <= din_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign bus.in_rdy     = rdy;
  assign bus.write      = write_q;
  assign bus.wr_adr     = wr_adr_q;
  assign bus.din        = din_q;
  assign bus.bp_thr     = BP_THR;
  assign bus.flush_done = flush_done;
  assign bus.wr_cnt     = wr_cnt_q;
endmodule
